random_gen_bank: RTL and testbench
==================================

# random_gen_bank

Parametrised multi-channel pseudo-random source for the POMDP/PBVI datapath. Generalises the fixed 16-bit single-channel generator: CHANNELS independent Galois LFSRs of configurable WIDTH, runtime reseeding with per-channel seed derivation, a warm-up phase, multi-step advance per draw, and a valid/ready output handshake. It feeds belief-sampling and observation-draw units that need one random word per channel per draw.

## Interface
- WIDTH, 16, LFSR width; legal values are 8, 16 or 32, and any other value is an elaboration error.
- CHANNELS, 4, number of independent LFSRs (1..16).
- STEPS, 1, LFSR steps applied per advance, unrolled combinationally (1..8).
- WARMUP, 4, cycles of free stepping after reset or reseed before output is valid (0..255).
- DEFAULT_SEED, 1, seed applied at reset.
---
- clk  in  1  clock; all logic on the rising edge.
- rst  in  1  asynchronous, active-high reset.
- seed_load  in  1  one-cycle pulse; loads `seed` and restarts warm-up.
- seed  in  WIDTH  base seed, sampled when seed_load=1.
- free_run  in  1  1 = advance every RUN cycle regardless of out_ready.
- out_ready  in  1  consumer accepts the draw.
- out_valid  out  1  the draw on `data` is valid.
- data  out  CHANNELS*WIDTH  channel k in bits [k*WIDTH +: WIDTH]; registered LFSR state.

## Operation
- Galois right-shift step: `s' = (s>>1) ^ (s[0] ? TAPS : 0)`.
  - TAPS for WIDTH=8: 0xB8.
  - TAPS for WIDTH=16: 0xB400.
  - TAPS for WIDTH=32: 0x80200003.
- Advance means STEPS consecutive steps in one cycle.
- Channel seed: `seed_k = seed ^ ((k*SALT) mod 2^WIDTH)`.
  - SALT for WIDTH=8, 16, 32: 0x9D, 0x9E37, 0x9E3779B9.
  - A zero result is replaced by 1, so the all-zero lockup state never occurs. Channel 0 uses `seed` itself.
- FSM states:
  - S_WARM: advance every cycle. The warm counter increments each cycle, and the FSM moves to S_RUN when the counter reaches WARMUP-1.
  - S_RUN: out_valid=1. Advance when (out_valid && out_ready) || free_run.
- If WARMUP=0, the FSM skips S_WARM and goes straight to S_RUN.
- seed_load has top priority in every state:
  - Next cycle: LFSRs = seed_k, warm counter = 0, FSM enters S_WARM (or S_RUN when WARMUP=0).
  - A handshake completing in the same cycle as seed_load counts as transferred; the advance it would cause is discarded.
- Reset:
  - LFSRs = DEFAULT_SEED-derived seed_k, warm counter = 0.
  - State = S_WARM, or S_RUN if WARMUP=0.
  - out_valid=0, or 1 if WARMUP=0.
  - data = the seed_k words.

## Timing
- seed_load sampled at edge t: data = seed_k at t+1. out_valid rises at t+1+WARMUP.
- Draw accepted at edge t: data advanced at t+1. out_valid stays 1, giving back-to-back draws at one per cycle.
- data is held stable while out_valid && !out_ready && !free_run.
- In free_run mode the consumer samples on its own schedule; there is no hold guarantee.
- Reset asserted mid-warm-up or mid-run returns immediately, asynchronously, to the reset values above.

## Configuration
- RNG_DRAW_CNT_EN defined:
  - Adds output `draw_cnt`, 32 bits, reset 0.
  - Increments on each out_valid && out_ready, wraps at 2^32.
  - Cleared on seed_load; the clear wins over a same-cycle increment.
- RNG_DRAW_CNT_EN undefined: the port and counter are absent.

## Structure
- Package `random_gen_pkg` holds:
  - the TAPS and SALT constant functions indexed by WIDTH;
  - the `rng_state_e` enum (S_WARM, S_RUN);
  - the function `lfsr_step(s, width)`.
- One sub-module, `lfsr_lane`: a single channel register with load and STEPS-unrolled advance, instantiated CHANNELS times in a generate loop. The FSM and warm counter live in the top.

## Test plan
- WIDTH=16, WARMUP=0, seed_load with seed=0x0001, out_ready=1: lane 0 data shows 0x0001, 0xB400, 0x5A00, 0x2D00 on consecutive cycles.
- Same configuration with STEPS=3: lane 0 shows 0x0001, then 0x2D00.
- CHANNELS=2, seed=0x9E37: lane 1 seed is 0 and is forced to 0x0001. Lane 0 = 0x9E37.
- WARMUP=4, seed_load at t: out_valid=0 during t+1..t+4 and rises at t+5. Hold out_ready=0 for 3 cycles: data is unchanged.
- seed_load coinciding with an accepted draw: the next data equals seed_k, not the advanced value. With RNG_DRAW_CNT_EN, draw_cnt=0.
- rst asserted in S_RUN: out_valid drops without waiting for a clock edge. After release, with WARMUP=4 and DEFAULT_SEED=1, out_valid returns after 4 cycles.

Source files
------------

// File: rtl/random_gen_pkg.sv
// Shared constants, state type and LFSR step function for random_gen_bank.
// Supports Galois right-shift LFSRs of width 8, 16 or 32.
package random_gen_pkg;

  typedef enum logic {
    S_WARM = 1'b0,
    S_RUN  = 1'b1
  } rng_state_e;

  // Feedback taps for a maximal-length Galois right-shift LFSR
  function automatic logic [31:0] taps_for(int width);
    case (width)
      8:       return 32'h0000_00B8;
      16:      return 32'h0000_B400;
      default: return 32'h8020_0003;
    endcase
  endfunction

  // Golden-ratio style salts used to decorrelate the per-channel seeds
  function automatic logic [31:0] salt_for(int width);
    case (width)
      8:       return 32'h0000_009D;
      16:      return 32'h0000_9E37;
      default: return 32'h9E37_79B9;
    endcase
  endfunction

  function automatic logic [31:0] mask_for(int width);
    if (width >= 32) return 32'hFFFF_FFFF;
    return (32'd1 << width) - 32'd1;
  endfunction

  // One Galois right-shift step, confined to the low 'width' bits
  function automatic logic [31:0] lfsr_step(logic [31:0] s, int width);
    logic [31:0] t;
    t = (s >> 1) ^ (s[0] ? taps_for(width) : 32'h0);
    return t & mask_for(width);
  endfunction

  // Seed for channel 'lane': base ^ (lane*SALT mod 2^width), zero forced to 1
  function automatic logic [31:0] seed_for_lane(logic [31:0] base, int lane, int width);
    logic [31:0] v;
    v = (base ^ (32'(lane) * salt_for(width))) & mask_for(width);
    if (v == 32'd0) v = 32'd1;
    return v;
  endfunction

endpackage

// File: rtl/random_gen_bank_lfsr_lane.sv
// lfsr_lane: one channel register of the random generator bank.
// Load has priority over advance; an advance applies STEPS unrolled steps.
module lfsr_lane
  import random_gen_pkg::*;
#(
  parameter int              WIDTH = 16,
  parameter int              STEPS = 1,
  parameter logic [WIDTH-1:0] INIT = '0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  input  logic             adv,
  output logic [WIDTH-1:0] q
);

  logic [31:0]      step_acc;
  logic [WIDTH-1:0] q_adv;

  // Combinational STEPS-deep unrolled advance of the current state
  always_comb begin
    step_acc = 32'(q);
    for (int i = 0; i < STEPS; i++) begin
      step_acc = lfsr_step(step_acc, WIDTH);
    end
    q_adv = WIDTH'(step_acc);
  end

  // Channel state register: reset seed, runtime load, or advance
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      q <= INIT;
    end else if (load) begin
      q <= load_val;
    end else if (adv) begin
      q <= q_adv;
    end
  end

endmodule

// File: rtl/random_gen_bank.sv
// random_gen_bank: CHANNELS independent Galois LFSRs with reseeding,
// warm-up and a valid/ready draw handshake.
// Optional feature macro: RNG_DRAW_CNT_EN adds a 32-bit accepted-draw counter
// output draw_cnt (cleared on seed_load).
module random_gen_bank
  import random_gen_pkg::*;
#(
  parameter int               WIDTH        = 16,
  parameter int               CHANNELS     = 4,
  parameter int               STEPS        = 1,
  parameter int               WARMUP       = 4,
  parameter logic [WIDTH-1:0] DEFAULT_SEED = 1
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      seed_load,
  input  logic [WIDTH-1:0]          seed,
  input  logic                      free_run,
  input  logic                      out_ready,
  output logic                      out_valid,
  output logic [CHANNELS*WIDTH-1:0] data
`ifdef RNG_DRAW_CNT_EN
  ,
  output logic [31:0]               draw_cnt
`endif
);

  if (!(WIDTH == 8 || WIDTH == 16 || WIDTH == 32)) begin : g_bad_width
    $error("random_gen_bank: WIDTH must be 8, 16 or 32");
  end
  if (CHANNELS < 1 || CHANNELS > 16) begin : g_bad_channels
    $error("random_gen_bank: CHANNELS must be 1..16");
  end
  if (STEPS < 1 || STEPS > 8) begin : g_bad_steps
    $error("random_gen_bank: STEPS must be 1..8");
  end
  if (WARMUP < 0 || WARMUP > 255) begin : g_bad_warmup
    $error("random_gen_bank: WARMUP must be 0..255");
  end

  localparam rng_state_e INIT_STATE = (WARMUP == 0) ? S_RUN : S_WARM;
  localparam logic       INIT_VALID = (WARMUP == 0);
  localparam logic [7:0] WARM_LAST  = (WARMUP == 0) ? 8'd0 : 8'(WARMUP - 1);

  rng_state_e state;
  logic [7:0] warm_cnt;
  logic       fire;
  logic       adv;

  assign fire = out_valid && out_ready;
  // During warm-up lanes free-step; seed_load overrides inside each lane
  assign adv  = (state == S_WARM) || fire || free_run;

  // Sequencer: warm-up countdown to RUN, restarted by reset or seed_load
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= INIT_STATE;
      warm_cnt  <= 8'd0;
      out_valid <= INIT_VALID;
    end else if (seed_load) begin
      state     <= INIT_STATE;
      warm_cnt  <= 8'd0;
      out_valid <= INIT_VALID;
    end else begin
      case (state)
        S_WARM: begin
          warm_cnt <= warm_cnt + 8'd1;
          if (warm_cnt == WARM_LAST) begin
            state     <= S_RUN;
            out_valid <= 1'b1;
          end
        end
        default: begin
          out_valid <= 1'b1;
        end
      endcase
    end
  end

  for (genvar k = 0; k < CHANNELS; k++) begin : g_lane
    localparam logic [WIDTH-1:0] INIT_K =
      WIDTH'(seed_for_lane(32'(DEFAULT_SEED), k, WIDTH));

    logic [WIDTH-1:0] lane_seed;
    assign lane_seed = WIDTH'(seed_for_lane(32'(seed), k, WIDTH));

    lfsr_lane #(
      .WIDTH (WIDTH),
      .STEPS (STEPS),
      .INIT  (INIT_K)
    ) u_lane (
      .clk      (clk),
      .rst      (rst),
      .load     (seed_load),
      .load_val (lane_seed),
      .adv      (adv),
      .q        (data[k*WIDTH +: WIDTH])
    );
  end

`ifdef RNG_DRAW_CNT_EN
  // Accepted-draw counter; a reseed clears it even if a draw lands that cycle
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      draw_cnt <= 32'd0;
    end else if (seed_load) begin
      draw_cnt <= 32'd0;
    end else if (fire) begin
      draw_cnt <= draw_cnt + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_random_gen_bank.sv
// Directed self-checking bench for random_gen_bank.
// dut_a: WARMUP=0, STEPS=1, CHANNELS=2; dut_b: WARMUP=0, STEPS=3;
// dut_c: defaults (WARMUP=4, STEPS=1, CHANNELS=4).
module tb_random_gen_bank;

  logic        clk;
  logic        rst;
  logic        seed_load;
  logic [15:0] seed;
  logic        free_run;
  logic        out_ready;

  logic        a_valid, b_valid, c_valid;
  logic [31:0] a_data;
  logic [63:0] b_data;
  logic [63:0] c_data;
`ifdef RNG_DRAW_CNT_EN
  logic [31:0] a_cnt, b_cnt, c_cnt;
`endif

  int passed = 0;
  int total  = 0;

  random_gen_bank #(.WIDTH(16), .CHANNELS(2), .STEPS(1), .WARMUP(0), .DEFAULT_SEED(16'h0001)) dut_a (
    .clk(clk), .rst(rst), .seed_load(seed_load), .seed(seed), .free_run(free_run),
    .out_ready(out_ready), .out_valid(a_valid), .data(a_data)
`ifdef RNG_DRAW_CNT_EN
    , .draw_cnt(a_cnt)
`endif
  );

  random_gen_bank #(.WIDTH(16), .CHANNELS(4), .STEPS(3), .WARMUP(0), .DEFAULT_SEED(16'h0001)) dut_b (
    .clk(clk), .rst(rst), .seed_load(seed_load), .seed(seed), .free_run(free_run),
    .out_ready(out_ready), .out_valid(b_valid), .data(b_data)
`ifdef RNG_DRAW_CNT_EN
    , .draw_cnt(b_cnt)
`endif
  );

  random_gen_bank dut_c (
    .clk(clk), .rst(rst), .seed_load(seed_load), .seed(seed), .free_run(free_run),
    .out_ready(out_ready), .out_valid(c_valid), .data(c_data)
`ifdef RNG_DRAW_CNT_EN
    , .draw_cnt(c_cnt)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic load_seed(input logic [15:0] s);
    seed      = s;
    seed_load = 1'b1;
    tick();
    seed_load = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    #2;
    total++; if (c_valid !== 1'b0) $display("FAIL reset_c_valid got %b want 0", c_valid); else passed++;
    total++; if (a_valid !== 1'b1) $display("FAIL reset_a_valid got %b want 1", a_valid); else passed++;
    total++; if (c_data !== 64'hDAA4_3C6F_9E36_0001) $display("FAIL reset_c_data got %h want daa43c6f9e360001", c_data); else passed++;
    total++; if (a_data !== 32'h9E36_0001) $display("FAIL reset_a_data got %h want 9e360001", a_data); else passed++;
`ifdef RNG_DRAW_CNT_EN
    total++; if (c_cnt !== 32'd0) $display("FAIL reset_draw_cnt got %0d want 0", c_cnt); else passed++;
`endif
    @(negedge clk);
    rst = 1'b0;
    #1;
  endtask

  task automatic test_sequence();
    logic [15:0] exp_a [4];
    exp_a = '{16'h0001, 16'hB400, 16'h5A00, 16'h2D00};
    out_ready = 1'b1;
    free_run  = 1'b0;
    load_seed(16'h0001);
    total++; if (b_data[15:0] !== 16'h0001) $display("FAIL seq_b_load got %h want 0001", b_data[15:0]); else passed++;
    for (int i = 0; i < 4; i++) begin
      if (i > 0) tick();
      total++;
      if (a_data[15:0] !== exp_a[i]) $display("FAIL seq_a_step%0d got %h want %h", i, a_data[15:0], exp_a[i]);
      else passed++;
      if (i == 1) begin
        total++; if (b_data[15:0] !== 16'h2D00) $display("FAIL seq_b_steps3 got %h want 2d00", b_data[15:0]); else passed++;
      end
    end
  endtask

  task automatic test_salt();
    out_ready = 1'b0;
    load_seed(16'h9E37);
    total++; if (a_data !== 32'h0001_9E37) $display("FAIL salt_a got %h want 00019e37", a_data); else passed++;
    total++; if (c_data !== 64'h4492_A259_0001_9E37) $display("FAIL salt_c got %h want 4492a25900019e37", c_data); else passed++;
    tick();
    total++; if (a_data !== 32'h0001_9E37) $display("FAIL salt_hold got %h want 00019e37", a_data); else passed++;
  endtask

  task automatic test_warmup();
    logic [15:0] exp_c [5];
    exp_c = '{16'h0001, 16'hB400, 16'h5A00, 16'h2D00, 16'h1680};
    out_ready = 1'b1;
    free_run  = 1'b0;
    load_seed(16'h0001);
    for (int i = 0; i < 5; i++) begin
      if (i > 0) tick();
      total++;
      if (c_valid !== (i == 4)) $display("FAIL warm_valid t+%0d got %b want %b", i + 1, c_valid, (i == 4));
      else passed++;
      total++;
      if (c_data[15:0] !== exp_c[i]) $display("FAIL warm_data t+%0d got %h want %h", i + 1, c_data[15:0], exp_c[i]);
      else passed++;
    end
    out_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      total++;
      if (c_data[15:0] !== 16'h1680 || c_valid !== 1'b1)
        $display("FAIL hold%0d got %h/%b want 1680/1", i, c_data[15:0], c_valid);
      else passed++;
    end
  endtask

  task automatic test_free_run();
    out_ready = 1'b0;
    free_run  = 1'b1;
    tick();
    total++; if (c_data[15:0] !== 16'h0B40) $display("FAIL free_run1 got %h want 0b40", c_data[15:0]); else passed++;
    tick();
    total++; if (c_data[15:0] !== 16'h05A0) $display("FAIL free_run2 got %h want 05a0", c_data[15:0]); else passed++;
    free_run = 1'b0;
  endtask

  task automatic test_back_to_back();
    out_ready = 1'b0;
    load_seed(16'h0001);
    out_ready = 1'b1;
    tick();
    tick();
    total++; if (a_data[15:0] !== 16'h5A00) $display("FAIL b2b_data got %h want 5a00", a_data[15:0]); else passed++;
`ifdef RNG_DRAW_CNT_EN
    total++; if (a_cnt !== 32'd2) $display("FAIL b2b_draw_cnt got %0d want 2", a_cnt); else passed++;
`endif
    load_seed(16'h0001);
    total++; if (a_data[15:0] !== 16'h0001) $display("FAIL collide_data got %h want 0001", a_data[15:0]); else passed++;
`ifdef RNG_DRAW_CNT_EN
    total++; if (a_cnt !== 32'd0) $display("FAIL collide_draw_cnt got %0d want 0", a_cnt); else passed++;
`endif
    out_ready = 1'b0;
  endtask

  task automatic test_async_reset();
    total++; if (c_valid !== 1'b1) $display("FAIL pre_reset_valid got %b want 1", c_valid); else passed++;
    rst = 1'b1;
    #1;
    total++; if (c_valid !== 1'b0) $display("FAIL async_valid got %b want 0", c_valid); else passed++;
    total++; if (c_data[15:0] !== 16'h0001) $display("FAIL async_data got %h want 0001", c_data[15:0]); else passed++;
    #2;
    rst = 1'b0;
    for (int i = 1; i <= 4; i++) begin
      tick();
      total++;
      if (c_valid !== (i == 4)) $display("FAIL rst_warm%0d got %b want %b", i, c_valid, (i == 4));
      else passed++;
    end
  endtask

  initial begin
    rst       = 1'b0;
    seed_load = 1'b0;
    seed      = 16'h0;
    free_run  = 1'b0;
    out_ready = 1'b0;
    #1;
    test_reset();
    test_sequence();
    test_salt();
    test_warmup();
    test_free_run();
    test_back_to_back();
    test_warmup();
    test_async_reset();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
